aes_128_inv_iter: RTL and testbench

//  Iterative AES-128 decryptor, the inverse direction of the unrolled aes_128 encryption datapath.
//  - Accepts one 128-bit ciphertext and key over valid/ready; returns plaintext over valid/ready.
//  - Expands the key forward to k10, then runs ten inverse rounds, one per cycle, with on-the-fly

---
 rtl/aes_128_inv_iter_pkg.sv | 71 +++++++
 rtl/aes_128_inv_iter_if.sv | 22 ++
 rtl/aes_128_inv_iter_inv_round.sv | 48 ++++
 rtl/aes_128_inv_iter.sv | 148 ++++++++++++++
 tb/tb_aes_128_inv_iter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_128_inv_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_128_inv_iter_pkg
//  Description : Shared AES types, round constants and GF(2^8) helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_128_inv_iter_pkg;

    localparam int RND_CNT_W = 4;
    typedef logic [RND_CNT_W-1:0] rnd_cnt_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEXP   = 3'd1,
        WHITEN = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } fsm_state_t;

    // RCON[i] is the round constant used to build round key i+1.
    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box built from inverse + affine map rather than a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        t = gf_inv(x);
        return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] t;
        t = rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05;
        return gf_inv(t);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_128_inv_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_128_inv_iter_if
//  Description : Ciphertext/key input and plaintext output handshake bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_128_inv_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] ct;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt;
    logic         busy;

    modport master (output in_valid, key, ct, out_ready,
                    input  in_ready, out_valid, pt, busy);
    modport slave  (input  in_valid, key, ct, out_ready,
                    output in_ready, out_valid, pt, busy);
endinterface
`default_nettype wire

// File: rtl/aes_128_inv_iter_inv_round.sv
`default_nettype none
// ============================================================================
//  Module      : aes_128_inv_iter_inv_round
//  Description : One combinational inverse round: InvShiftRows, InvSubBytes,
//                AddRoundKey, then InvMixColumns unless i_last is set.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_128_inv_iter_inv_round
    import aes_128_inv_iter_pkg::*;
(
    input  wire logic [127:0] i_state,
    input  wire logic [127:0] i_key,
    input  wire logic         i_last,
    output logic      [127:0] o_state
);

    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    assign w_ark = w_isb ^ i_key;

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        // Row r of column c is taken from column (c - r) mod 4 of the input.
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            localparam int c_DST = 4 * gc + gr;
            localparam int c_SRC = 4 * ((gc - gr + 4) % 4) + gr;
            assign w_isb[127-8*c_DST -: 8] = inv_sbox(i_state[127-8*c_SRC -: 8]);
        end

        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_ark[127-32*gc -: 8];
        assign w_a1 = w_ark[119-32*gc -: 8];
        assign w_a2 = w_ark[111-32*gc -: 8];
        assign w_a3 = w_ark[103-32*gc -: 8];

        assign w_imc[127-32*gc -: 32] = {
            gf_mul(8'h0e, w_a0) ^ gf_mul(8'h0b, w_a1) ^ gf_mul(8'h0d, w_a2) ^ gf_mul(8'h09, w_a3),
            gf_mul(8'h09, w_a0) ^ gf_mul(8'h0e, w_a1) ^ gf_mul(8'h0b, w_a2) ^ gf_mul(8'h0d, w_a3),
            gf_mul(8'h0d, w_a0) ^ gf_mul(8'h09, w_a1) ^ gf_mul(8'h0e, w_a2) ^ gf_mul(8'h0b, w_a3),
            gf_mul(8'h0b, w_a0) ^ gf_mul(8'h0d, w_a1) ^ gf_mul(8'h09, w_a2) ^ gf_mul(8'h0e, w_a3)
        };
    end

    assign o_state = i_last ? w_ark : w_imc;

endmodule
`default_nettype wire

// File: rtl/aes_128_inv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_128_inv_iter
//  Description : Iterative AES-128 decryptor. Expands the key forward to k10
//                (or reuses a cached k10), then runs ten inverse rounds with
//                an on-the-fly inverse key schedule, one round per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_128_inv_iter
    import aes_128_inv_iter_pkg::*;
#(
    parameter bit CACHE_KEY = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    aes_128_inv_iter_if.slave bus
);

    localparam rnd_cnt_t c_LAST_RND = rnd_cnt_t'(9);

    fsm_state_t   r_state;
    rnd_cnt_t     r_cnt;
    logic [127:0] r_blk;
    logic [127:0] r_key;
    logic [127:0] r_pt;
    logic         r_out_valid;
    logic [127:0] r_tag;
    logic [127:0] r_cache_k10;
    logic         r_cache_v;

    logic [7:0]   w_rcon;
    logic [127:0] w_key_fwd;
    logic [127:0] w_key_inv;
    logic [127:0] w_round_out;
    logic         w_hit;

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0]  ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    // The counter counts 0..9 in KEXP and 9..0 in ROUND, so RCON[r_cnt]
    // is the right constant in both directions.
    assign w_rcon    = RCON[r_cnt];
    assign w_key_fwd = fwd_key(r_key, w_rcon);
    assign w_key_inv = inv_key(r_key, w_rcon);
    assign w_hit     = CACHE_KEY && r_cache_v && (bus.key == r_tag);

    aes_128_inv_iter_inv_round u_round (
        .i_state (r_blk),
        .i_key   (w_key_inv),
        .i_last  (r_cnt == '0),
        .o_state (w_round_out)
    );

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.pt        = r_pt;

    // Control FSM with key schedule, round datapath registers and k10 cache.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_blk       <= '0;
            r_key       <= '0;
            r_pt        <= '0;
            r_out_valid <= 1'b0;
            r_tag       <= '0;
            r_cache_k10 <= '0;
            r_cache_v   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_blk <= bus.ct;
                        if (w_hit) begin
                            r_key   <= r_cache_k10;
                            r_cnt   <= c_LAST_RND;
                            r_state <= WHITEN;
                        end else begin
                            // Invalidate until this expansion finishes, so the
                            // new tag is never paired with the old k10.
                            r_key     <= bus.key;
                            r_tag     <= bus.key;
                            r_cache_v <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    r_key <= w_key_fwd;
                    if (r_cnt == c_LAST_RND) begin
                        r_cache_k10 <= w_key_fwd;
                        r_cache_v   <= CACHE_KEY;
                        r_state     <= WHITEN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WHITEN: begin
                    r_blk   <= r_blk ^ r_key;
                    r_cnt   <= c_LAST_RND;
                    r_state <= ROUND;
                end
                ROUND: begin
                    r_key <= w_key_inv;
                    r_blk <= w_round_out;
                    if (r_cnt == '0) begin
                        r_pt        <= w_round_out;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_128_inv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_128_inv_iter
//  Description : Self-checking bench for aes_128_inv_iter: known-answer
//                vectors, key cache, backpressure, mid-block reset and random
//                blocks encrypted by a software AES-128 model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_128_inv_iter;

    localparam logic [127:0] c_K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_128_inv_iter_if bus ();

    aes_128_inv_iter #(.CACHE_KEY(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   m_sbox [256];
    bit           m_cache_v = 1'b0;
    logic [127:0] m_cache_key = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box by walking generator 3 and its inverse through the field.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ m_rl(q, 1) ^ m_rl(q, 2) ^ m_rl(q, 3) ^ m_rl(q, 4);
            m_sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        m_sbox[0] = 8'h63;
    endtask

    // Textbook AES-128 encryption on a byte array.
    function automatic logic [127:0] m_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]], m_sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = m_xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) u[n] = m_sbox[s[n]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[4*c+rr] = u[4*((c+rr)%4)+rr];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
                    s[4*c+3] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) r[127-8*n -: 8] = s[n];
        return r;
    endfunction

    // One block: rdy_dly < 0 means out_ready is already high at accept;
    // otherwise out_ready rises rdy_dly cycles after out_valid is seen.
    task automatic do_block(input string tag, input logic [127:0] k, input logic [127:0] c,
                            input logic [127:0] p, input int rdy_dly, input bit chk_k10,
                            input bit stress);
        int   exp_lat, lat, waitc, bad_pt, bad_rdy, bad_ov, bad_busy;
        bit   hit;
        hit     = m_cache_v && (k == m_cache_key);
        exp_lat = hit ? 12 : 22;
        waitc   = 0;
        while (!bus.in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) chk({tag, " in_ready wait"}, 128'(bus.in_ready), 128'd1);
        bus.key       = k;
        bus.ct        = c;
        bus.in_valid  = 1'b1;
        bus.out_ready = (rdy_dly < 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            if (chk_k10 && lat == 11) chk({tag, " k10"}, dut.r_key, c_K10);
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, " pt"}, bus.pt, p);
        if (!hit) begin
            m_cache_key = k;
            m_cache_v   = 1'b1;
        end
        bad_pt = 0; bad_rdy = 0; bad_ov = 0; bad_busy = 0;
        for (int i = 0; i < rdy_dly; i++) begin
            if (stress) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.key      = {$urandom, $urandom, $urandom, $urandom};
                bus.ct       = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            if (bus.pt !== p)        bad_pt++;
            if (bus.in_ready !== 0)  bad_rdy++;
            if (bus.out_valid !== 1) bad_ov++;
        end
        if (stress) begin
            chk({tag, " pt unstable cycles"}, 128'(bad_pt), 128'd0);
            chk({tag, " in_ready high cycles"}, 128'(bad_rdy), 128'd0);
            chk({tag, " out_valid dropped cycles"}, 128'(bad_ov), 128'd0);
            bus.in_valid = 1'b1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({tag, " out_valid after transfer"}, 128'(bus.out_valid), 128'd0);
        if (stress) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (bus.busy !== 0 || bus.out_valid !== 0) bad_busy++;
            end
            chk({tag, " activity after transfer"}, 128'(bad_busy), 128'd0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] rk, rp, prev_key;
        bit           have_prev;
        build_sbox();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.key       = '0;
        bus.ct        = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset pt", bus.pt, 128'd0);
        chk("reset busy", 128'(bus.busy), 128'd0);
        chk("reset in_ready", 128'(bus.in_ready), 128'd1);
        rst_n = 1'b1;
        @(negedge clk);

        do_block("fips c1", c_K1, c_C1, c_P1, -1, 1'b0, 1'b0);
        do_block("fips b", c_K2, c_C2, c_P2, 2, 1'b1, 1'b0);
        do_block("cache hit", c_K2, c_C2, c_P2, 0, 1'b0, 1'b0);
        do_block("cache miss", c_K1, c_C1, c_P1, 1, 1'b0, 1'b0);
        do_block("backpressure", c_K1, c_C1, c_P1, 50, 1'b0, 1'b1);

        // Abort a cached-key block in the middle of its ROUND phase.
        bus.key      = c_K1;
        bus.ct       = c_C1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid-block busy", 128'(bus.busy), 128'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort out_valid", 128'(bus.out_valid), 128'd0);
        chk("abort pt", bus.pt, 128'd0);
        chk("abort in_ready", 128'(bus.in_ready), 128'd1);
        chk("abort busy", 128'(bus.busy), 128'd0);
        rst_n     = 1'b1;
        m_cache_v = 1'b0;
        @(negedge clk);
        do_block("after abort", c_K1, c_C1, c_P1, 0, 1'b0, 1'b0);

        have_prev = 1'b0;
        prev_key  = '0;
        for (int i = 0; i < 1000; i++) begin
            if (have_prev && $urandom_range(0, 9) < 3) rk = prev_key;
            else rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            do_block("random", rk, m_encrypt(rk, rp), rp,
                     int'($urandom_range(0, 4)) - 1, 1'b0, 1'b0);
            prev_key  = rk;
            have_prev = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
